pkt_counter_bank: RTL and testbench
===================================

Name: pkt_counter_bank

Overview:
- Statistics counter bank for the transaction-layer output path.
- Counts packets popped from the four output FIFOs, one counter per lane, plus an aggregate total counter.
- Sits directly upstream of the counter read-out mux: cnt0..cnt3 feed its per-lane inputs and cnt4 (total) feeds its fifth input.
- Driven by the same one-hot main-FSM state vector as the read-out mux, so counts freeze while they are being read.

Parameters:
- WIDTH, 8, bit width of every counter and of the cnt* outputs.
- LANES, 4, number of FIFO pop strobes. Fixed at 4 in this release; cnt0..cnt3 and the total assume 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- state  input  4  one-hot main FSM state: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE.
- pop  input  LANES  per-lane FIFO pop strobes. Bit i is 1 for each cycle a packet leaves FIFO i.
- cnt0, cnt1, cnt2, cnt3  output  WIDTH  per-lane packet counts (registered).
- cnt4  output  WIDTH  total packet count across all lanes (registered).
- sat  output  LANES+1  sticky saturation flags. Bits 0..3 are the lanes; bit 4 is the total.

Behaviour:
- One clock; reset is synchronous and active-high. All state changes occur on rising clk.
- Reset: on any edge with reset=1, cnt0..cnt4=0 and sat=0. reset dominates state and pop.
- All outputs come directly from flops: no combinational path from pop or state to any output.
- state=RESET (0001): same clear as reset. Counters and sat go to 0 on the next edge.
- state=INIT (0010): all counters and sat hold. pop is ignored.
- state=IDLE (0100): all counters and sat hold, so read-out values stay stable. pop is ignored.
- state=ACTIVE (1000): counting is enabled.
- Any other state encoding (zero or multi-hot): hold everything. No error output.
- Latency: a pop sampled at edge k shows up in cnt* immediately after edge k (1-cycle latency).
- Lane counter i, when ACTIVE and pop[i]=1:
  - If cnt_i < 2^WIDTH-1, cnt_i increments by 1.
  - If cnt_i == 2^WIDTH-1, cnt_i holds and sat[i] is set.
- Total counter, when ACTIVE:
  - pc = popcount(pop), range 0..4.
  - sum = cnt4 + pc, computed in WIDTH+3 bits.
  - If sum <= 2^WIDTH-1, cnt4 = sum. Otherwise cnt4 = 2^WIDTH-1 and sat[4] is set.
  - pc=0 leaves cnt4 and sat[4] unchanged.
- Counters never wrap. Saturation is terminal until the next reset or RESET state.
- sat bits are sticky. Only reset or state=RESET clears them.
- Multiple lanes popping in the same cycle are all counted. There is no per-lane arbitration.
- Reset or RESET state mid-burst: the clear wins in that cycle and pops in that cycle are lost. Counting resumes on the first ACTIVE cycle after the clear.
- Invariant while no sat bit is set: cnt4 == cnt0+cnt1+cnt2+cnt3.

Decomposition:
- Shared package holds:
  - state encoding constants ST_RESET=4'b0001, ST_INIT=4'b0010, ST_IDLE=4'b0100, ST_ACTIVE=4'b1000, also used by the read-out mux and the main FSM;
  - the default WIDTH.
- One sub-module, sat_inc_counter, with parameters WIDTH and INCW:
  - inputs: clk, reset, clr, en, inc[INCW-1:0];
  - outputs: q[WIDTH-1:0], sat.
- Instantiate sat_inc_counter five times: four lanes with INCW=1, inc=pop[i]; the total with INCW=3, inc=popcount.
- clr = (state==ST_RESET); en = (state==ST_ACTIVE).
- The top level contains the popcount logic and the wiring only.

Test Plan:
- Reset then ACTIVE, pop=0001 for 5 cycles -> cnt0=5, cnt1..cnt3=0, cnt4=5, sat=0.
- ACTIVE, pop=1111 for 3 cycles -> each lane cnt=3, cnt4=12; each value visible on the edge after its pop.
- Pops while state=IDLE or INIT (pop=1111 for 4 cycles), starting from cnt0=2 -> all counts unchanged (cnt0 stays 2); then state=0011 (illegal) with pops -> still unchanged.
- ACTIVE, preload cnt4=253 via prior pops, then pop=1111 for one cycle -> cnt4=255, sat[4]=1. Next pop=0010 -> cnt4 stays 255, cnt1 increments, sat[1]=0.
- Lane saturation: 256 cycles of pop=0100 -> cnt2=255, sat[2]=1 on the 256th pop, cnt4=255, sat[4]=1. A further 10 pops leave both held.
- Reset mid-burst: pop=1111 in ACTIVE with reset=1 on cycle 3 -> all cnt*=0 and sat=0 after that edge; pops on cycles 4..5 give cnt0..3=2 and cnt4=8. Repeat the sequence using state=RESET instead of reset -> identical result.

Source files
------------

// File: rtl/pkt_counter_bank_pkg.sv
// rtl/pkt_counter_bank_pkg.sv - shared state encoding and counter width for the counter bank
package pkt_counter_bank_pkg;

    // One-hot main FSM states, shared with the read-out mux and the main FSM
    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/sat_inc_counter.sv
// rtl/sat_inc_counter.sv - saturating counter with a multi-bit increment and a sticky saturation flag
module sat_inc_counter #(
    parameter int WIDTH = 8,
    parameter int INCW  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [INCW-1:0]  inc,
    output logic [WIDTH-1:0] q,
    output logic             sat
);

    localparam int SW = WIDTH + INCW;
    localparam logic [SW-1:0] MAX = {{INCW{1'b0}}, {WIDTH{1'b1}}};

    // Widened so the true sum is visible before clamping
    logic [SW-1:0] sum;

    assign sum = {{INCW{1'b0}}, q} + {{WIDTH{1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q   <= '0;
            sat <= 1'b0;
        end else if (en) begin
            if (sum > MAX) begin
                q   <= '1;
                sat <= 1'b1;
            end else begin
                q   <= sum[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/pkt_counter_bank.sv
// rtl/pkt_counter_bank.sv - per-lane and total FIFO pop counters gated by the main FSM state
module pkt_counter_bank
    import pkt_counter_bank_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       state,
    input  logic [LANES-1:0] pop,
    output logic [WIDTH-1:0] cnt0,
    output logic [WIDTH-1:0] cnt1,
    output logic [WIDTH-1:0] cnt2,
    output logic [WIDTH-1:0] cnt3,
    output logic [WIDTH-1:0] cnt4,
    output logic [LANES:0]   sat
);

    logic             clr;
    logic             en;
    logic [2:0]       pc;
    logic [WIDTH-1:0] lane_q [LANES];

    // Illegal encodings match neither compare, so everything holds
    assign clr = (state == ST_RESET);
    assign en  = (state == ST_ACTIVE);

    always_comb begin
        pc = '0;
        for (int i = 0; i < LANES; i++) begin
            pc = pc + {2'b00, pop[i]};
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sat_inc_counter #(
            .WIDTH (WIDTH),
            .INCW  (1)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .en    (en),
            .inc   (pop[i]),
            .q     (lane_q[i]),
            .sat   (sat[i])
        );
    end

    sat_inc_counter #(
        .WIDTH (WIDTH),
        .INCW  (3)
    ) u_total (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .inc   (pc),
        .q     (cnt4),
        .sat   (sat[LANES])
    );

    assign cnt0 = lane_q[0];
    assign cnt1 = lane_q[1];
    assign cnt2 = lane_q[2];
    assign cnt3 = lane_q[3];

endmodule

// File: tb/tb_pkt_counter_bank.sv
// tb/tb_pkt_counter_bank.sv - randomized and directed checks of pkt_counter_bank against a reference model
module tb_pkt_counter_bank;

    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state;
    logic [3:0] pop;
    logic [7:0] cnt0, cnt1, cnt2, cnt3, cnt4;
    logic [4:0] sat;

    int m_cnt [5];
    bit m_sat [5];
    int n_checks = 0;
    int n_pass   = 0;

    pkt_counter_bank #(.WIDTH(8), .LANES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .state (state),
        .pop   (pop),
        .cnt0  (cnt0),
        .cnt1  (cnt1),
        .cnt2  (cnt2),
        .cnt3  (cnt3),
        .cnt4  (cnt4),
        .sat   (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int model_sat();
        int v = 0;
        for (int i = 0; i < 5; i++) if (m_sat[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic model_update(input logic r, input logic [3:0] s, input logic [3:0] p);
        int pc;
        if (r || s == 4'b0001) begin
            for (int i = 0; i < 5; i++) begin
                m_cnt[i] = 0;
                m_sat[i] = 0;
            end
        end else if (s == 4'b1000) begin
            pc = 0;
            for (int i = 0; i < 4; i++) begin
                if (p[i]) begin
                    pc++;
                    if (m_cnt[i] == MAXV) m_sat[i] = 1;
                    else m_cnt[i]++;
                end
            end
            if (m_cnt[4] + pc > MAXV) begin
                m_cnt[4] = MAXV;
                m_sat[4] = 1;
            end else begin
                m_cnt[4] += pc;
            end
        end
    endtask

    task automatic compare_model();
        check("cnt0", int'(cnt0), m_cnt[0]);
        check("cnt1", int'(cnt1), m_cnt[1]);
        check("cnt2", int'(cnt2), m_cnt[2]);
        check("cnt3", int'(cnt3), m_cnt[3]);
        check("cnt4", int'(cnt4), m_cnt[4]);
        check("sat",  int'(sat),  model_sat());
    endtask

    task automatic step(input logic r, input logic [3:0] s, input logic [3:0] p);
        reset = r;
        state = s;
        pop   = p;
        @(posedge clk);
        #1;
        model_update(r, s, p);
        compare_model();
    endtask

    task automatic do_reset();
        step(1'b1, 4'b0100, 4'b1111);
        step(1'b0, 4'b0100, 4'b0000);
    endtask

    initial begin
        reset = 1'b1;
        state = 4'b0001;
        pop   = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            m_cnt[i] = 0;
            m_sat[i] = 0;
        end

        // Reset state
        do_reset();
        check("rst_cnt0", int'(cnt0), 0);
        check("rst_cnt4", int'(cnt4), 0);
        check("rst_sat",  int'(sat),  0);

        // Single lane counting
        repeat (5) step(1'b0, 4'b1000, 4'b0001);
        check("l0_cnt0", int'(cnt0), 5);
        check("l0_cnt1", int'(cnt1), 0);
        check("l0_cnt4", int'(cnt4), 5);
        check("l0_sat",  int'(sat),  0);

        // All lanes, visible one edge after each pop
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 4'b1000, 4'b1111);
            check("all_cnt3", int'(cnt3), k);
            check("all_cnt4", int'(cnt4), 4 * k);
        end

        // Hold in IDLE, INIT and an illegal encoding
        do_reset();
        repeat (2) step(1'b0, 4'b1000, 4'b0001);
        repeat (4) step(1'b0, 4'b0100, 4'b1111);
        repeat (4) step(1'b0, 4'b0010, 4'b1111);
        check("hold_cnt0", int'(cnt0), 2);
        repeat (4) step(1'b0, 4'b0011, 4'b1111);
        check("ill_cnt0", int'(cnt0), 2);
        check("ill_cnt4", int'(cnt4), 2);

        // Total saturation from 253
        do_reset();
        repeat (63) step(1'b0, 4'b1000, 4'b1111);
        step(1'b0, 4'b1000, 4'b0001);
        check("pre_cnt4", int'(cnt4), 253);
        step(1'b0, 4'b1000, 4'b1111);
        check("tsat_cnt4", int'(cnt4), 255);
        check("tsat_sat",  int'(sat),  5'b10000);
        step(1'b0, 4'b1000, 4'b0010);
        check("tsat_hold", int'(cnt4), 255);
        check("tsat_cnt1", int'(cnt1), 65);
        check("tsat_sat1", int'(sat[1]), 0);

        // Lane saturation
        do_reset();
        repeat (255) step(1'b0, 4'b1000, 4'b0100);
        check("l2_255_cnt", int'(cnt2), 255);
        check("l2_255_sat", int'(sat), 0);
        step(1'b0, 4'b1000, 4'b0100);
        check("l2_sat_cnt2", int'(cnt2), 255);
        check("l2_sat_cnt4", int'(cnt4), 255);
        check("l2_sat_sat",  int'(sat),  5'b10100);
        repeat (10) step(1'b0, 4'b1000, 4'b0100);
        check("l2_held_cnt2", int'(cnt2), 255);
        check("l2_held_sat",  int'(sat),  5'b10100);

        // Mid-burst clear by reset, then by RESET state
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            repeat (2) step(1'b0, 4'b1000, 4'b1111);
            if (pass == 0) step(1'b1, 4'b1000, 4'b1111);
            else           step(1'b0, 4'b0001, 4'b1111);
            check("mid_clr_cnt4", int'(cnt4), 0);
            check("mid_clr_sat",  int'(sat),  0);
            repeat (2) step(1'b0, 4'b1000, 4'b1111);
            check("mid_cnt0", int'(cnt0), 2);
            check("mid_cnt3", int'(cnt3), 2);
            check("mid_cnt4", int'(cnt4), 8);
        end

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int      sel;
            logic [3:0] s;
            logic       r;
            sel = int'($urandom_range(0, 39));
            if (sel < 28)      s = 4'b1000;
            else if (sel < 32) s = 4'b0100;
            else if (sel < 35) s = 4'b0010;
            else if (sel < 36) s = 4'b0001;
            else               s = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 199) == 0);
            step(r, s, 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
